// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI register peripheral
// Contents:
//   state_e         FSM state encoding (IDLE, CMD, WRITE, READ)
//   cmd_rw_bit()    bit position of the R/W flag in a command word
//   sample_on_rise() SPI mode decode: 1 when data is sampled on the rising sclk edge
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    // The R/W flag is the first bit on the wire, i.e. the MSB of the word.
    function automatic int cmd_rw_bit(input int data_w);
        return data_w - 1;
    endfunction

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// rtl/spi_reg_peripheral_if.sv - SPI pin bundle between host and target
// Signals:
//   ss       slave select, active-low (host -> target)
//   sclk     SPI clock (host -> target)
//   mosi     host -> target data
//   miso     target -> host data
//   miso_oe  target tri-state enable for miso
// Modports: master (host side), slave (target side).
interface spi_reg_peripheral_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output ss, output sclk, output mosi, input miso, input miso_oe);
    modport slave  (input ss, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-bit pin synchroniser with rise/fall strobes
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   din_i      asynchronous pin inputs
//   sync_o     synchronised levels
//   rise_o     1-cycle strobe on a synchronised 0->1 transition
//   fall_o     1-cycle strobe on a synchronised 1->0 transition
// All flops (including the edge-detect history) reset to RESET_VAL so that no
// spurious edge is reported when reset is released.
module spi_sync_edge #(
    parameter int               WIDTH       = 3,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= RESET_VAL;
            end
            prev_q <= RESET_VAL;
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI target with addressed register bank and burst access
// Ports:
//   clk, rst    system clock (>= 4x sclk), synchronous active-high reset
//   spi         SPI pins (slave modport): ss, sclk, mosi in; miso, miso_oe out
//   stat_i      read sources, word k at [k*DATA_W +: DATA_W] (word 0 replaced by ID_VALUE)
//   cfg_o       written register bank, same packing as stat_i
//   wr_en       1-cycle pulse per committed write word, with wr_addr / wr_data
//   busy        frame in progress (FSM not idle)
//   frame_err   1-cycle pulse when ss rises with a partial word received
module spi_reg_peripheral
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 3,
    parameter int                CPOL        = 0,
    parameter int                CPHA        = 0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(8'hAA)
) (
    input  logic                           clk,
    input  logic                           rst,
    spi_reg_peripheral_if.slave            spi,
    input  logic [(2**ADDR_W)*DATA_W-1:0]  stat_i,
    output logic [(2**ADDR_W)*DATA_W-1:0]  cfg_o,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [DATA_W-1:0]              wr_data,
    output logic                           busy,
    output logic                           frame_err
);

    localparam int NUM_REGS    = 2**ADDR_W;
    localparam int CNT_W       = $clog2(DATA_W);
    localparam int RW_BIT      = cmd_rw_bit(DATA_W);
    localparam bit SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    // Pin order {ss, sclk, mosi}; idle is ss high, sclk at CPOL, mosi low.
    localparam logic [2:0] PIN_IDLE = {1'b1, (CPOL != 0), 1'b0};

    logic [2:0] pin_s, pin_rise, pin_fall;

    spi_sync_edge #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (PIN_IDLE)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  ({spi.ss, spi.sclk, spi.mosi}),
        .sync_o (pin_s),
        .rise_o (pin_rise),
        .fall_o (pin_fall)
    );

    logic ss_s, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;
    assign ss_s      = pin_s[2];
    assign ss_rise   = pin_rise[2];
    assign ss_fall   = pin_fall[2];
    assign sclk_rise = pin_rise[1];
    assign sclk_fall = pin_fall[1];
    assign mosi_s    = pin_s[0];

    logic unused_pins;
    assign unused_pins = ^{pin_s[1], pin_rise[0], pin_fall[0]};

    // ss_rise keeps the frame open for one more cycle so that an sclk edge
    // coinciding with ss release is still sampled before the frame closes.
    logic ss_active, sample_edge, launch_edge;
    assign ss_active   = ~ss_s | ss_rise;
    assign sample_edge = ss_active & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign launch_edge = ss_active & (SAMPLE_RISE ? sclk_fall : sclk_rise);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]            rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]            tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         miso_q, miso_d;
    logic [NUM_REGS*DATA_W-1:0]   cfg_q, cfg_d;
    logic                         wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]            wr_data_q, wr_data_d;
    logic                         frame_err_q, frame_err_d;

    // Incoming word including the bit being sampled this cycle.
    logic [DATA_W-1:0] word;
    assign word = {rx_sr_q, mosi_s};

    // Read source: while still in CMD the start address comes straight from
    // the command word completing this cycle.
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    assign rd_addr = (state_q == ST_CMD) ? word[ADDR_W-1:0] : addr_q;
    assign rd_data = (rd_addr == '0) ? ID_VALUE : stat_i[rd_addr*DATA_W +: DATA_W];

    logic word_done;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        cfg_d       = cfg_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    tx_sr_d   = '0;
                end
            end
            default: begin
                if (sample_edge) begin
                    rx_sr_d = word[DATA_W-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end

                if (launch_edge) begin
                    miso_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = tx_sr_q << 1;
                end

                if (word_done) begin
                    case (state_q)
                        ST_CMD: begin
                            if (word[RW_BIT]) begin
                                state_d = ST_READ;
                                tx_sr_d = rd_data;
                                addr_d  = word[ADDR_W-1:0] + 1'b1;
                            end else begin
                                state_d = ST_WRITE;
                                addr_d  = word[ADDR_W-1:0];
                            end
                        end
                        ST_WRITE: begin
                            cfg_d[addr_q*DATA_W +: DATA_W] = word;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = word;
                            addr_d    = addr_q + 1'b1;
                        end
                        ST_READ: begin
                            tx_sr_d = rd_data;
                            addr_d  = addr_q + 1'b1;
                        end
                        default: ;
                    endcase
                end

                // End of frame is judged after this cycle's sample has been taken.
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_d != '0);
                    bit_cnt_d   = '0;
                    miso_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            cfg_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            cfg_q       <= cfg_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cfg_o       = cfg_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign spi.miso    = miso_q;
    assign spi.miso_oe = ~ss_s;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - scoreboard bench over all four SPI modes
module tb_spi_reg_peripheral;

    localparam int HALF = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] ss_v, sclk_v;
    logic       mosi_v;
    logic [3:0] miso_v, oe_v, wr_en_v, busy_v, ferr_v;
    logic [63:0] cfg_v [4];
    logic [2:0]  wr_addr_v [4];
    logic [7:0]  wr_data_v [4];

    logic [7:0]  stat_model [8];
    logic [63:0] stat_bus;
    logic [7:0]  cfg_model [4][8];

    typedef struct packed {
        logic [1:0] m;
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr_q [$];
    int         exp_ferr_q [$];
    logic [7:0] exp_rx_q [$];
    logic [7:0] host_rx_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    always_comb begin
        stat_bus = '0;
        for (int k = 0; k < 8; k++) stat_bus[k*8 +: 8] = stat_model[k];
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_peripheral_if sif();
        assign sif.ss   = ss_v[g];
        assign sif.sclk = sclk_v[g];
        assign sif.mosi = mosi_v;
        assign miso_v[g] = sif.miso;
        assign oe_v[g]   = sif.miso_oe;

        spi_reg_peripheral #(
            .DATA_W(8), .ADDR_W(3), .CPOL(g / 2), .CPHA(g % 2),
            .SYNC_STAGES(2), .ID_VALUE(8'hAA)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .spi       (sif),
            .stat_i    (stat_bus),
            .cfg_o     (cfg_v[g]),
            .wr_en     (wr_en_v[g]),
            .wr_addr   (wr_addr_v[g]),
            .wr_data   (wr_data_v[g]),
            .busy      (busy_v[g]),
            .frame_err (ferr_v[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] rd_model(input int a);
        return (a == 0) ? 8'hAA : stat_model[a];
    endfunction

    function automatic logic [63:0] pack_cfg(input int m);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = cfg_model[m][k];
        return r;
    endfunction

    // Monitors: compare DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (wr_en_v[g]) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    chk("wr_word", {g[1:0], wr_addr_v[g], wr_data_v[g]}, 64'(e));
                end
            end
            if (ferr_v[g]) begin
                if (exp_ferr_q.size() == 0) chk("frame_err_unexpected", 64'd1, 64'd0);
                else chk("frame_err_mode", 64'(g), 64'(exp_ferr_q.pop_front()));
            end
        end
        while (host_rx_q.size() > 0) begin
            logic [7:0] act;
            act = host_rx_q.pop_front();
            if (exp_rx_q.size() == 0) chk("miso_unexpected", 64'd1, 64'd0);
            else chk("miso_word", 64'(act), 64'(exp_rx_q.pop_front()));
        end
    end

    // Reference model: what a frame should do, from the command/burst rules.
    task automatic plan(input int m, input logic [7:0] words[$], input int last_bits,
                        input bit end_frame);
        int  nfull;
        bit  is_rd;
        int  a;
        wr_t e;
        nfull = (last_bits == 8) ? words.size() : words.size() - 1;
        is_rd = words[0][7];
        a     = int'(words[0][2:0]);
        for (int w = 0; w < nfull; w++) begin
            if (w == 0) exp_rx_q.push_back(8'h00);
            else if (is_rd) begin
                exp_rx_q.push_back(rd_model(a));
                a = (a + 1) % 8;
            end else begin
                exp_rx_q.push_back(8'h00);
                cfg_model[m][a] = words[w];
                e.m = m[1:0];
                e.a = a[2:0];
                e.d = words[w];
                exp_wr_q.push_back(e);
                a = (a + 1) % 8;
            end
        end
        if (last_bits != 8 && end_frame) exp_ferr_q.push_back(m);
    endtask

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    // SPI host: shifts words MSB first; the last word may be cut to last_bits.
    task automatic xfer(input int m, input logic [7:0] words[$], input int last_bits,
                        input bit end_frame);
        bit cpol, cpha;
        int nb;
        logic [7:0] rxw, cur;
        cpol = bit'(m / 2);
        cpha = bit'(m % 2);
        ss_v[m] = 1'b0;
        half_wait();
        for (int w = 0; w < words.size(); w++) begin
            nb  = (w == words.size() - 1) ? last_bits : 8;
            rxw = '0;
            cur = words[w];
            for (int b = 0; b < nb; b++) begin
                if (!cpha) begin
                    mosi_v = cur[7-b];
                    half_wait();
                    sclk_v[m] = ~cpol;
                    rxw = {rxw[6:0], miso_v[m]};
                    half_wait();
                    sclk_v[m] = cpol;
                end else begin
                    sclk_v[m] = ~cpol;
                    mosi_v = cur[7-b];
                    half_wait();
                    sclk_v[m] = cpol;
                    rxw = {rxw[6:0], miso_v[m]};
                    half_wait();
                end
            end
            if (nb == 8) host_rx_q.push_back(rxw);
        end
        half_wait();
        if (end_frame) begin
            ss_v[m] = 1'b1;
            mosi_v  = 1'b0;
            half_wait();
            half_wait();
        end
    endtask

    task automatic frame(input int m, input logic [7:0] words[$], input int last_bits);
        plan(m, words, last_bits, 1'b1);
        xfer(m, words, last_bits, 1'b1);
        chk($sformatf("cfg_m%0d", m), cfg_v[m], pack_cfg(m));
        chk($sformatf("busy_idle_m%0d", m), 64'(busy_v[m]), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q [$];
        int m, n;

        rst    = 1'b1;
        ss_v   = 4'hF;
        sclk_v = 4'b1100;
        mosi_v = 1'b0;
        for (int k = 0; k < 8; k++) stat_model[k] = 8'($urandom);
        stat_model[1] = 8'h3C;
        stat_model[5] = 8'h5C;
        for (int g = 0; g < 4; g++) for (int k = 0; k < 8; k++) cfg_model[g][k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_cfg_m%0d", g), cfg_v[g], 64'd0);
            chk($sformatf("rst_outs_m%0d", g),
                {miso_v[g], oe_v[g], wr_en_v[g], busy_v[g], ferr_v[g], wr_addr_v[g], wr_data_v[g]},
                64'd0);
        end
        repeat (4) @(negedge clk);

        q = {8'h02, 8'h11, 8'h22};         frame(0, q, 8);
        chk("cfg_word2", 64'(cfg_v[0][23:16]), 64'h11);
        chk("cfg_word3", 64'(cfg_v[0][31:24]), 64'h22);
        q = {8'h80, 8'h00, 8'h00};         frame(0, q, 8);
        for (int g = 0; g < 4; g++) begin
            q = {8'h85, 8'h00};            frame(g, q, 8);
        end
        q = {8'h07, 8'hA1, 8'hB2};         frame(0, q, 8);
        chk("cfg_wrap7", 64'(cfg_v[0][63:56]), 64'hA1);
        chk("cfg_wrap0", 64'(cfg_v[0][7:0]), 64'hB2);
        q = {8'h02, 8'h5A};                frame(0, q, 3);

        for (int i = 0; i < 16; i++) begin
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            for (int k = 1; k < 8; k++) stat_model[k] = 8'($urandom);
            q.delete();
            q.push_back({1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom)});
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            frame(m, q, 8);
        end

        // Reset in the middle of a read data word.
        q = {8'h80, 8'h00};
        plan(0, q, 3, 1'b0);
        xfer(0, q, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ss_v[0] = 1'b1;
        for (int g = 0; g < 4; g++) for (int k = 0; k < 8; k++) cfg_model[g][k] = '0;
        chk("midrst_cfg", cfg_v[0], 64'd0);
        chk("midrst_outs",
            {miso_v[0], oe_v[0], wr_en_v[0], busy_v[0], ferr_v[0], wr_addr_v[0], wr_data_v[0]},
            64'd0);
        repeat (8) @(negedge clk);
        q = {8'h81, 8'h00, 8'h00};         frame(0, q, 8);
        q = {8'h03, 8'h77};                frame(0, q, 8);

        repeat (20) @(negedge clk);
        chk("wr_queue_empty",   64'(exp_wr_q.size()),   64'd0);
        chk("ferr_queue_empty", 64'(exp_ferr_q.size()), 64'd0);
        chk("rx_queue_empty",   64'(exp_rx_q.size()),   64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
